// File: rtl/simple_fixed_point_multiplier_pkg.sv
// Shared definitions for the sequential signed fixed-point multiplier:
// FSM encoding, default Q-format widths and the bit-counter width helper.
package simple_fixed_point_multiplier_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_FRAC_BITS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter must hold the value DATA_WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  localparam int unsigned DEF_CNT_WIDTH = cnt_width(DEF_DATA_WIDTH);

endpackage

// File: rtl/fixed_point_round_saturate.sv
// Scales a 2W-bit product magnitude back to Q format, applies the sign and saturates.
// SIMPLE_FIXED_POINT_MULTIPLIER_ROUND_EN selects round-half-away-from-zero over truncation.
module fixed_point_round_saturate
  import simple_fixed_point_multiplier_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic [2*DATA_WIDTH-1:0] i_mag,
  input  logic                    i_sign,
  output logic [DATA_WIDTH-1:0]   o_data_c,
  output logic                    o_overflow_c
);

  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam logic [PW-1:0] POS_LIM = (PW'(1) << (DATA_WIDTH - 1)) - PW'(1);
  localparam logic [PW-1:0] NEG_LIM = PW'(1) << (DATA_WIDTH - 1);

  logic [PW-1:0] w_scaled;

`ifdef SIMPLE_FIXED_POINT_MULTIPLIER_ROUND_EN
  localparam logic [PW-1:0] HALF_LSB = PW'(1) << (FRAC_BITS - 1);
  assign w_scaled = (i_mag + HALF_LSB) >> FRAC_BITS;
`else
  assign w_scaled = i_mag >> FRAC_BITS;
`endif

  // Negative side allows one extra step of magnitude; zero negates to +0.
  always_comb begin
    o_data_c     = '0;
    o_overflow_c = 1'b0;
    if (!i_sign) begin
      if (w_scaled > POS_LIM) begin
        o_data_c     = POS_LIM[DATA_WIDTH-1:0];
        o_overflow_c = 1'b1;
      end else begin
        o_data_c = w_scaled[DATA_WIDTH-1:0];
      end
    end else begin
      if (w_scaled > NEG_LIM) begin
        o_data_c     = NEG_LIM[DATA_WIDTH-1:0];
        o_overflow_c = 1'b1;
      end else begin
        o_data_c = DATA_WIDTH'(0) - w_scaled[DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/simple_fixed_point_signed_multiplier.sv
// Iterative shift-and-add signed Q-format multiplier, one multiplier bit per clock.
// Rounding is enabled by SIMPLE_FIXED_POINT_MULTIPLIER_ROUND_EN (see fixed_point_round_saturate).
module simple_fixed_point_signed_multiplier
  import simple_fixed_point_multiplier_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_multiplicand,
  input  logic [DATA_WIDTH-1:0] i_multiplier,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_overflow
);

  localparam int unsigned PW    = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W = cnt_width(DATA_WIDTH);

  state_e                r_state;
  state_e                w_next;
  logic [PW-1:0]         r_mcand;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [PW-1:0]         r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_sign;
  logic                  r_ready;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_overflow;
  logic [DATA_WIDTH-1:0] w_mag_a;
  logic [DATA_WIDTH-1:0] w_mag_b;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_ovf;

  // Unsigned magnitudes; the most negative value maps to 2^(W-1).
  assign w_mag_a = i_multiplicand[DATA_WIDTH-1] ? (~i_multiplicand + DATA_WIDTH'(1)) : i_multiplicand;
  assign w_mag_b = i_multiplier[DATA_WIDTH-1]   ? (~i_multiplier + DATA_WIDTH'(1))   : i_multiplier;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_valid) w_next = ST_RUN;
      ST_RUN:  if (r_cnt == CNT_W'(1)) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  fixed_point_round_saturate #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_round_sat (
    .i_mag        (r_acc),
    .i_sign       (r_sign),
    .o_data_c     (w_res),
    .o_overflow_c (w_ovf)
  );

  // Shift-add datapath and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_sign     <= 1'b0;
      r_ready    <= 1'b1;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_valid) begin
            r_mcand  <= PW'(w_mag_a);
            r_mplier <= w_mag_b;
            r_sign   <= i_multiplicand[DATA_WIDTH-1] ^ i_multiplier[DATA_WIDTH-1];
            r_acc    <= '0;
            r_cnt    <= CNT_W'(DATA_WIDTH);
            r_ready  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CNT_W'(1);
        end
        ST_DONE: begin
          r_data     <= w_res;
          r_overflow <= w_ovf;
          r_valid    <= 1'b1;
          r_ready    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_ready    = r_ready;
  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_simple_fixed_point_signed_multiplier.sv
// Self-checking bench for simple_fixed_point_signed_multiplier (Q4.4): vector table,
// scoreboard queue with latency tracking, and hand sequences for busy/back-to-back/reset.
module tb_simple_fixed_point_signed_multiplier;

  localparam int unsigned W   = 8;
  localparam int unsigned LAT = W + 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       ov;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       ov;
    int         acc_cyc;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_valid;
  logic [7:0] i_a;
  logic [7:0] i_b;
  logic       o_ready;
  logic       o_valid;
  logic [7:0] o_data;
  logic       o_overflow;

  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  sb_t  sb[$];
  vec_t vecs[$];

  simple_fixed_point_signed_multiplier dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_multiplicand (i_a),
    .i_multiplier   (i_b),
    .o_valid        (o_valid),
    .o_data         (o_data),
    .o_overflow     (o_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact integer product, then scale/round, sign and saturate.
  function automatic vec_t model(input logic [7:0] a, input logic [7:0] b);
    vec_t r;
    int sa;
    int sb2;
    int p;
    int m;
    sa = $signed(a);
    sb2 = $signed(b);
    p = sa * sb2;
    m = (p < 0) ? -p : p;
`ifdef SIMPLE_FIXED_POINT_MULTIPLIER_ROUND_EN
    m = (m + 8) >>> 4;
`else
    m = m >>> 4;
`endif
    r.a = a;
    r.b = b;
    r.ov = 1'b0;
    if (p >= 0) begin
      if (m > 127) begin r.d = 8'h7F; r.ov = 1'b1; end
      else r.d = 8'(m);
    end else begin
      if (m > 128) begin r.d = 8'h80; r.ov = 1'b1; end
      else r.d = 8'(-m);
    end
    return r;
  endfunction

  // Scoreboard consumer: every o_valid must match the oldest pending expectation.
  always @(negedge clk) begin
    sb_t e;
    if (rst_n && o_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got o_valid=1 data=0x%0h expected no result", o_data);
      end else begin
        e = sb.pop_front();
        check("data", 32'(o_data), 32'(e.d));
        check("overflow", 32'(o_overflow), 32'(e.ov));
        check("latency", 32'(cyc - e.acc_cyc), 32'(LAT));
      end
    end
  end

  // Drive an operand pair now (caller is at a negedge with o_ready high).
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d, input logic ov);
    sb_t e;
    i_valid = 1'b1;
    i_a = a;
    i_b = b;
    e.d = d;
    e.ov = ov;
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_a = 8'($urandom);
    i_b = 8'($urandom);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d, input logic ov);
    int t;
    t = 0;
    @(negedge clk);
    while (!o_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!o_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got o_ready=0 expected 1");
    end else begin
      issue(a, b, d, ov);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
    end
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    int   t;
    int   nvalid;

    rst_n = 1'b0;
    i_valid = 1'b0;
    i_a = 8'h00;
    i_b = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_overflow", 32'(o_overflow), 32'd0);
    rst_n = 1'b1;

    vecs.push_back('{8'h18, 8'h20, 8'h30, 1'b0});
    vecs.push_back('{8'hE8, 8'h20, 8'hD0, 1'b0});
    vecs.push_back('{8'hE8, 8'hE0, 8'h30, 1'b0});
    vecs.push_back('{8'h00, 8'h80, 8'h00, 1'b0});
    vecs.push_back('{8'h7F, 8'h7F, 8'h7F, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 8'h7F, 1'b1});
    vecs.push_back('{8'h80, 8'h10, 8'h80, 1'b0});
    vecs.push_back('{8'h10, 8'h80, 8'h80, 1'b0});
    vecs.push_back('{8'h80, 8'hF0, 8'h7F, 1'b1});
`ifdef SIMPLE_FIXED_POINT_MULTIPLIER_ROUND_EN
    vecs.push_back('{8'h01, 8'h08, 8'h01, 1'b0});
    vecs.push_back('{8'hFF, 8'h08, 8'hFF, 1'b0});
`else
    vecs.push_back('{8'h01, 8'h08, 8'h00, 1'b0});
    vecs.push_back('{8'hFF, 8'h08, 8'h00, 1'b0});
`endif
    for (int i = 0; i < 10; i++) vecs.push_back(model(8'($urandom), 8'($urandom)));

    for (int i = 0; i < vecs.size(); i++) do_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].ov);
    drain();

    // Operand strobe during RUN must be ignored.
    do_op(8'h18, 8'h20, 8'h30, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("busy_ready_low", 32'(o_ready), 32'd0);
    i_valid = 1'b1;
    i_a = 8'h7F;
    i_b = 8'h7F;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    drain();

    // Back-to-back: accept the next pair on the o_valid cycle.
    do_op(8'hE8, 8'h20, 8'hD0, 1'b0);
    t = 0;
    @(negedge clk);
    while (!o_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("b2b_valid_seen", 32'(o_valid), 32'd1);
    check("b2b_ready", 32'(o_ready), 32'd1);
    issue(8'h7F, 8'h7F, 8'h7F, 1'b1);
    drain();

    // Reset at E4 aborts the operation with no result.
    do_op(8'h18, 8'h20, 8'h30, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_data", 32'(o_data), 32'd0);
    check("abort_overflow", 32'(o_overflow), 32'd0);
    check("abort_valid", 32'(o_valid), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(o_ready), 32'd1);
    nvalid = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (o_valid) nvalid++;
    end
    check("abort_no_valid", 32'(nvalid), 32'd0);

    do_op(8'h80, 8'h10, 8'h80, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
